// File: rtl/decoder_3x8_pulse.sv
// Registered 3-to-8 decoder / pulse generator with valid/ready input handshake.
// Optional even-parity checking on the input code is enabled by defining DEC_PARITY_EN.
module decoder_3x8_pulse #(
    parameter int PULSE_LEN = 4,
    parameter int GAP_LEN   = 1,
    parameter int CNT_W     = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       in_valid,
    input  logic [2:0] in_code,
`ifdef DEC_PARITY_EN
    input  logic       in_parity,
    output logic       parity_err,
`endif
    output logic       in_ready,
    output logic [7:0] out,
    output logic       out_valid,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        GAP
    } state_t;

    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_LEN - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD   = (GAP_LEN > 0) ? CNT_W'(GAP_LEN - 1) : '0;

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [7:0]       out_next;
    logic             accept;
    logic             code_ok;
    logic             perr_next;

`ifdef DEC_PARITY_EN
    assign code_ok = ~(^{in_parity, in_code});
`else
    assign code_ok = 1'b1;
`endif

    // in_ready is gated by rst so it drops the moment reset is asserted.
    assign in_ready  = en && !rst && (state == IDLE);
    assign accept    = in_valid && in_ready;
    assign out_valid = |out;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            out   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            out   <= out_next;
        end
    end

`ifdef DEC_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity_err <= 1'b0;
        end else begin
            parity_err <= perr_next;
        end
    end
`endif

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        out_next   = out;
        perr_next  = 1'b0;

        case (state)
            IDLE: begin
                if (accept) begin
                    if (code_ok) begin
                        out_next   = 8'(1) << in_code;
                        cnt_next   = PULSE_LOAD;
                        state_next = ACTIVE;
                    end else begin
                        perr_next = 1'b1;
                    end
                end
            end
            ACTIVE: begin
                if (cnt == '0) begin
                    out_next = '0;
                    if (GAP_LEN == 0) begin
                        state_next = IDLE;
                        cnt_next   = '0;
                    end else begin
                        state_next = GAP;
                        cnt_next   = GAP_LOAD;
                    end
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            GAP: begin
                if (cnt == '0) begin
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
                out_next   = '0;
            end
        endcase

        // Dropping enable aborts any pulse or gap in progress.
        if (!en) begin
            state_next = IDLE;
            cnt_next   = '0;
            out_next   = '0;
        end
    end

endmodule

// File: tb/tb_decoder_3x8_pulse.sv
// Self-checking bench for decoder_3x8_pulse: two instances (default timing and
// PULSE_LEN=1/GAP_LEN=0) checked against a schedule-based reference model.
module tb_decoder_3x8_pulse;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       in_valid;
    logic [2:0] in_code;
`ifdef DEC_PARITY_EN
    logic       in_parity;
    logic       derr [2];
`endif

    logic [7:0] dout   [2];
    logic       dvalid [2];
    logic       dbusy  [2];
    logic       dready [2];

    always #5 clk = ~clk;

    decoder_3x8_pulse u0 (
        .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_code(in_code),
`ifdef DEC_PARITY_EN
        .in_parity(in_parity), .parity_err(derr[0]),
`endif
        .in_ready(dready[0]), .out(dout[0]), .out_valid(dvalid[0]), .busy(dbusy[0])
    );

    decoder_3x8_pulse #(.PULSE_LEN(1), .GAP_LEN(0), .CNT_W(8)) u1 (
        .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_code(in_code),
`ifdef DEC_PARITY_EN
        .in_parity(in_parity), .parity_err(derr[1]),
`endif
        .in_ready(dready[1]), .out(dout[1]), .out_valid(dvalid[1]), .busy(dbusy[1])
    );

    // Reference model: each instance is described only by the cycle its last
    // code was accepted; outputs follow from the pulse/gap timeline.
    int         plen [2] = '{4, 1};
    int         glen [2] = '{1, 0};
    int         acc_cyc [2];
    logic [2:0] acc_code [2];
    bit         perr_exp [2];
    bit         got_acc [2];
    int         cyc;
    int         total;
    int         bad;

    typedef struct {
        bit         en;
        bit         vld;
        logic [2:0] code;
        logic [7:0] eout;
        bit         ebusy;
        bit         eready;
    } vec_t;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            acc_cyc[d]  = -100000;
            acc_code[d] = 3'd0;
            perr_exp[d] = 1'b0;
            got_acc[d]  = 1'b0;
        end
    endtask

    // One clock cycle: compare at the falling edge, then advance the model.
    task automatic tick(input string tag);
        bit         acc [2];
        bit         abort [2];
        bit         perr_now [2];
        logic [2:0] code_s;
        @(negedge clk);
        code_s = in_code;
        for (int d = 0; d < 2; d++) begin
            int         ph;
            logic [7:0] eo;
            logic       eb;
            logic       er;
            ph = cyc - acc_cyc[d];
            eb = (ph >= 1) && (ph <= plen[d] + glen[d]);
            eo = (ph >= 1 && ph <= plen[d]) ? (8'd1 << acc_code[d]) : 8'd0;
            er = en && !eb;
            check($sformatf("%s/u%0d/out", tag, d), dout[d], eo);
            check($sformatf("%s/u%0d/out_valid", tag, d), {7'd0, dvalid[d]}, {7'd0, (eo != 8'd0)});
            check($sformatf("%s/u%0d/busy", tag, d), {7'd0, dbusy[d]}, {7'd0, eb});
            check($sformatf("%s/u%0d/in_ready", tag, d), {7'd0, dready[d]}, {7'd0, er});
`ifdef DEC_PARITY_EN
            check($sformatf("%s/u%0d/parity_err", tag, d), {7'd0, derr[d]}, {7'd0, perr_exp[d]});
            perr_now[d] = in_valid && er && (^{in_parity, code_s});
`else
            perr_now[d] = 1'b0;
`endif
            acc[d]   = in_valid && er;
            abort[d] = !en && eb;
        end
        @(posedge clk);
        #1;
        cyc++;
        for (int d = 0; d < 2; d++) begin
            got_acc[d]  = acc[d] && !perr_now[d];
            perr_exp[d] = perr_now[d];
            if (abort[d]) acc_cyc[d] = -100000;
            if (got_acc[d]) begin
                acc_cyc[d]  = cyc - 1;
                acc_code[d] = code_s;
            end
        end
    endtask

    // Pulses rst between clock edges and checks that outputs clear at once.
    task automatic applyReset(input string tag);
        rst = 1'b1;
        #2;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("%s/u%0d/out", tag, d), dout[d], 8'h00);
            check($sformatf("%s/u%0d/out_valid", tag, d), {7'd0, dvalid[d]}, 8'h00);
            check($sformatf("%s/u%0d/busy", tag, d), {7'd0, dbusy[d]}, 8'h00);
            check($sformatf("%s/u%0d/in_ready", tag, d), {7'd0, dready[d]}, 8'h00);
        end
        rst = 1'b0;
        model_reset();
    endtask

    task automatic idle_ticks(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) tick("idle");
    endtask

    initial begin
        vec_t tbl [7];
        int   n;
        int   prev_t;
        int   n_acc;

        total    = 0;
        bad      = 0;
        cyc      = 0;
        rst      = 1'b1;
        en       = 1'b0;
        in_valid = 1'b0;
        in_code  = 3'd0;
`ifdef DEC_PARITY_EN
        in_parity = 1'b0;
`endif
        model_reset();

        tbl[0] = '{1'b1, 1'b1, 3'd3, 8'h00, 1'b0, 1'b1};
        tbl[1] = '{1'b1, 1'b0, 3'd0, 8'h08, 1'b1, 1'b0};
        tbl[2] = '{1'b1, 1'b0, 3'd0, 8'h08, 1'b1, 1'b0};
        tbl[3] = '{1'b1, 1'b0, 3'd0, 8'h08, 1'b1, 1'b0};
        tbl[4] = '{1'b1, 1'b0, 3'd0, 8'h08, 1'b1, 1'b0};
        tbl[5] = '{1'b1, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0};
        tbl[6] = '{1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 1'b1};

        #1;
        applyReset("por");
        en = 1'b1;
        idle_ticks(2);

        // Reset asserted in the middle of a code-5 pulse.
        in_valid = 1'b1;
        in_code  = 3'd5;
        tick("t1acc");
        in_valid = 1'b0;
        tick("t1p1");
        tick("t1p2");
        check("t1/mid_out", dout[0], 8'h20);
        applyReset("t1rst");
        tick("t1after");

        // Table: single code 3 with default timing.
        for (int i = 0; i < 7; i++) begin
            en       = tbl[i].en;
            in_valid = tbl[i].vld;
            in_code  = tbl[i].code;
            #3;
            check($sformatf("t2/row%0d/out", i), dout[0], tbl[i].eout);
            check($sformatf("t2/row%0d/busy", i), {7'd0, dbusy[0]}, {7'd0, tbl[i].ebusy});
            check($sformatf("t2/row%0d/in_ready", i), {7'd0, dready[0]}, {7'd0, tbl[i].eready});
            tick($sformatf("t2row%0d", i));
        end

        // All eight codes back to back, source holding each until consumed.
        prev_t = 0;
        for (int k = 0; k < 8; k++) begin
            in_code  = 3'(k);
            in_valid = 1'b1;
            n = 0;
            do begin
                tick($sformatf("t3c%0d", k));
                n++;
            end while (!got_acc[0] && n < 20);
            check_int($sformatf("t3/accepted%0d", k), int'(got_acc[0]), 1);
            check($sformatf("t3/code%0d", k), {5'd0, acc_code[0]}, 8'(k));
            if (k > 0) check_int($sformatf("t3/spacing%0d", k), (cyc - 1) - prev_t, 6);
            prev_t = cyc - 1;
        end
        in_valid = 1'b0;
        idle_ticks(7);

        // Enable dropped on the second cycle of a code-7 pulse.
        in_valid = 1'b1;
        in_code  = 3'd7;
        tick("t4acc");
        in_valid = 1'b0;
        tick("t4p1");
        en       = 1'b0;
        in_valid = 1'b1;
        in_code  = 3'd2;
        tick("t4p2");
        #3;
        check("t4/abort_out", dout[0], 8'h00);
        check("t4/abort_busy", {7'd0, dbusy[0]}, 8'h00);
        check("t4/abort_ready", {7'd0, dready[0]}, 8'h00);
        for (int i = 0; i < 3; i++) begin
            tick("t4hold");
            check_int("t4/not_consumed", int'(got_acc[0]), 0);
        end
        en = 1'b1;
        tick("t4resume");
        check_int("t4/resume_acc", int'(got_acc[0]), 1);
        check("t4/resume_code", {5'd0, acc_code[0]}, 8'h02);
        in_valid = 1'b0;
        idle_ticks(7);

        // Short-timing instance: a held source gets a code every 2 cycles.
        in_valid = 1'b1;
        n_acc = 0;
        for (int i = 0; i < 8; i++) begin
            in_code = 3'(i);
            tick("t5");
            if (got_acc[1]) n_acc++;
        end
        check_int("t5/accept_count", n_acc, 4);
        idle_ticks(7);

`ifdef DEC_PARITY_EN
        in_code   = 3'd6;
        in_parity = 1'b1;
        in_valid  = 1'b1;
        tick("t6bad");
        in_valid = 1'b0;
        #3;
        check("t6/perr_hi", {7'd0, derr[0]}, 8'h01);
        check("t6/bad_out", dout[0], 8'h00);
        tick("t6gap");
        #3;
        check("t6/perr_lo", {7'd0, derr[0]}, 8'h00);
        in_parity = 1'b0;
        in_valid  = 1'b1;
        tick("t6good");
        in_valid = 1'b0;
        #3;
        check("t6/good_out", dout[0], 8'h40);
        idle_ticks(7);
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            en       = ($urandom_range(9) != 0);
            in_valid = $urandom_range(1) == 1;
            in_code  = 3'($urandom_range(7));
`ifdef DEC_PARITY_EN
            in_parity = (^in_code) ^ ($urandom_range(7) == 0);
`endif
            tick("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
